// File: rtl/hand_zone_tracker.sv
// Per-frame, per-colour zone hit accumulator with a thresholded, multi-frame-stable
// winning-zone result; sits between the pixel colour classifiers and the gesture decoder.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for a sof pixel; all other pixels ignored
// ACCUM   | frame open, counting hits per zone and tracking running maxima
// RESOLVE | one cycle: apply threshold/stability filter, publish result
module hand_zone_tracker #(
   parameter int NX            = 10,
   parameter int NY            = 8,
   parameter int ZONES         = NX * NY,
   parameter int ZB            = $clog2(ZONES),
   parameter int NCOLOR        = 2,
   parameter int CNT_W         = 16,
   parameter int MIN_COUNT     = 64,
   parameter int STABLE_FRAMES = 3
) (
   input  logic                      pclk,
   input  logic                      rst_n,
   input  logic                      pix_valid,
   input  logic                      sof,
   input  logic                      eof,
   input  logic [ZB-1:0]             zone_id,
   input  logic [NCOLOR-1:0]         color_hit,
   output logic                      res_valid,
   output logic [NCOLOR*ZB-1:0]      zone_out,
   output logic [NCOLOR-1:0]         present,
   output logic [NCOLOR*CNT_W-1:0]   cnt_out,
   output logic                      frame_err
);

   localparam int                RW      = $clog2(STABLE_FRAMES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [CNT_W-1:0]  MIN_L   = CNT_W'(MIN_COUNT);
   localparam logic [RW-1:0]     SF_L    = RW'(STABLE_FRAMES);
   localparam logic [ZB:0]       ZONES_L = (ZB + 1)'(ZONES);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt      [NCOLOR][ZONES];
   logic [CNT_W-1:0]  max_cnt  [NCOLOR];
   logic [ZB-1:0]     max_zone [NCOLOR];
   logic [ZB-1:0]     cand     [NCOLOR];
   logic [RW-1:0]     run      [NCOLOR];

   logic              clear;
   logic              count_en;
   logic [CNT_W-1:0]  base;
   logic [CNT_W-1:0]  n_val    [NCOLOR];
   logic [NCOLOR-1:0] upd;
   logic [NCOLOR-1:0] hit;
   logic [NCOLOR-1:0] same;
   logic [RW-1:0]     run_nx   [NCOLOR];

   // A sof pixel counts against freshly cleared state, so the clear is folded into
   // the increment/compare path instead of costing an extra cycle.
   always_comb begin
      clear    = pix_valid && sof && (state != RESOLVE);
      count_en = pix_valid && ({1'b0, zone_id} < ZONES_L) && ((state == ACCUM) || clear);
      base     = '0;
      upd      = '0;
      hit      = '0;
      same     = '0;
      for (int c = 0; c < NCOLOR; c++) begin
         base     = clear ? '0 : cnt[c][zone_id];
         n_val[c] = (base == CNT_MAX) ? base : base + 1'b1;
         upd[c]   = count_en && color_hit[c] &&
                    ((n_val[c] > (clear ? '0 : max_cnt[c])) ||
                     (zone_id == (clear ? '0 : max_zone[c])));
         hit[c]   = (max_cnt[c] >= MIN_L);
         same[c]  = (max_zone[c] == cand[c]);
         if (!hit[c])
            run_nx[c] = '0;
         else if (!same[c])
            run_nx[c] = RW'(1);
         else
            run_nx[c] = (run[c] == SF_L) ? SF_L : run[c] + 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         res_valid <= 1'b0;
         frame_err <= 1'b0;
         zone_out  <= '0;
         present   <= '0;
         cnt_out   <= '0;
         for (int c = 0; c < NCOLOR; c++) begin
            max_cnt[c]  <= '0;
            max_zone[c] <= '0;
            cand[c]     <= '0;
            run[c]      <= '0;
            for (int z = 0; z < ZONES; z++)
               cnt[c][z] <= '0;
         end
      end else begin
         res_valid <= 1'b0;
         frame_err <= 1'b0;

         if (clear) begin
            for (int c = 0; c < NCOLOR; c++) begin
               max_cnt[c]  <= '0;
               max_zone[c] <= '0;
               for (int z = 0; z < ZONES; z++)
                  cnt[c][z] <= '0;
            end
         end

         // Later assignments win over the clear above for the pixel's own zone.
         for (int c = 0; c < NCOLOR; c++) begin
            if (count_en && color_hit[c]) begin
               cnt[c][zone_id] <= n_val[c];
               if (upd[c]) begin
                  max_cnt[c]  <= n_val[c];
                  max_zone[c] <= zone_id;
               end
            end
         end

         case (state)
            IDLE: begin
               if (pix_valid && sof)
                  state <= eof ? RESOLVE : ACCUM;
            end
            ACCUM: begin
               if (pix_valid) begin
                  if (sof)
                     frame_err <= 1'b1;
                  if (eof)
                     state <= RESOLVE;
               end
            end
            RESOLVE: begin
               state     <= IDLE;
               res_valid <= 1'b1;
               for (int c = 0; c < NCOLOR; c++) begin
                  run[c]                      <= run_nx[c];
                  cnt_out[c*CNT_W +: CNT_W]   <= max_cnt[c];
                  if (!hit[c]) begin
                     present[c] <= 1'b0;
                  end else begin
                     cand[c] <= max_zone[c];
                     if (run_nx[c] == SF_L) begin
                        zone_out[c*ZB +: ZB] <= max_zone[c];
                        present[c]           <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
